// File: rtl/timer_bank.sv
// Bank of N_CH memory-mapped timer/counter channels with per-channel prescaler,
// auto-reload or one-shot overflow, and write-1-to-clear pending interrupts.
module timer_bank #(
   parameter int          N_CH      = 4,
   parameter int          CNT_W     = 32,
   parameter int          PRE_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout
);

   localparam logic [31:0]      CH_SPAN = 32'(16 * N_CH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   logic [CNT_W-1:0] th   [N_CH];
   logic [CNT_W-1:0] tl   [N_CH];
   logic [PRE_W-1:0] pre  [N_CH];
   logic [PRE_W-1:0] pcnt [N_CH];
   logic [N_CH-1:0]  en;
   logic [N_CH-1:0]  ie;
   logic [N_CH-1:0]  oneshot;
   logic [N_CH-1:0]  pend;

   logic [31:0]      off;
   logic             ch_hit;
   logic             pend_hit;
   logic             stat_hit;
   logic [2:0]       ch_sel;
   logic [1:0]       reg_sel;

   logic [N_CH-1:0]  we_th;
   logic [N_CH-1:0]  we_tl;
   logic [N_CH-1:0]  we_ctrl;
   logic [N_CH-1:0]  we_pre;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  ovf;
   logic [N_CH-1:0]  pend_clr;

   // Offsets below BASE_ADDR wrap to huge values and therefore never hit.
   always_comb begin
      off      = addr - BASE_ADDR;
      ch_hit   = (off < CH_SPAN) && (off[1:0] == 2'b00);
      pend_hit = (off == CH_SPAN);
      stat_hit = (off == CH_SPAN + 32'd4);
      ch_sel   = off[6:4];
      reg_sel  = off[3:2];
   end

   // A CPU write to TL masks the overflow of that same edge.
   always_comb begin
      we_th    = '0;
      we_tl    = '0;
      we_ctrl  = '0;
      we_pre   = '0;
      tick     = '0;
      ovf      = '0;
      pend_clr = (wr && pend_hit) ? wdata[N_CH-1:0] : '0;
      for (int i = 0; i < N_CH; i++) begin
         if (wr && ch_hit && (ch_sel == 3'(i))) begin
            we_th[i]   = (reg_sel == 2'd0);
            we_tl[i]   = (reg_sel == 2'd1);
            we_ctrl[i] = (reg_sel == 2'd2);
            we_pre[i]  = (reg_sel == 2'd3);
         end
         tick[i] = en[i] && (pcnt[i] == pre[i]);
         ovf[i]  = tick[i] && (tl[i] == '1) && !we_tl[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            th[i]   <= '0;
            tl[i]   <= '0;
            pre[i]  <= '0;
            pcnt[i] <= '0;
         end
         en      <= '0;
         ie      <= '0;
         oneshot <= '0;
         pend    <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (we_th[i])
               th[i] <= wdata[CNT_W-1:0];
            if (we_pre[i])
               pre[i] <= wdata[PRE_W-1:0];

            if (we_tl[i])
               tl[i] <= wdata[CNT_W-1:0];
            else if (tick[i])
               tl[i] <= (tl[i] == '1) ? th[i] : tl[i] + CNT_ONE;

            if (we_ctrl[i]) begin
               en[i]      <= wdata[0];
               ie[i]      <= wdata[1];
               oneshot[i] <= wdata[2];
            end else if (ovf[i] && oneshot[i]) begin
               en[i] <= 1'b0;
            end

            // Prescaler restarts on a new divisor or when the channel stops.
            if (!en[i] || we_pre[i] || tick[i] || (we_ctrl[i] && !wdata[0]))
               pcnt[i] <= '0;
            else
               pcnt[i] <= pcnt[i] + PRE_ONE;
         end
         pend <= ovf | (pend & ~pend_clr);
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (ch_hit) begin
            for (int i = 0; i < N_CH; i++) begin
               if (ch_sel == 3'(i)) begin
                  case (reg_sel)
                     2'd0:    rdata = 32'(th[i]);
                     2'd1:    rdata = 32'(tl[i]);
                     2'd2:    rdata = {29'd0, oneshot[i], ie[i], en[i]};
                     default: rdata = 32'(pre[i]);
                  endcase
               end
            end
         end else if (pend_hit) begin
            rdata = 32'(pend);
         end else if (stat_hit) begin
            rdata = 32'(en);
         end
      end
   end

   assign irqout = |(pend & ie);

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: reads push expected rdata/irqout into a queue,
// and a negedge monitor pops and compares whenever a read is on the bus.
module tb_timer_bank;

   localparam logic [31:0] B = 32'h4000_0100;
   localparam logic [31:0] G = 32'h4000_0140;

   logic        clk = 1'b0;
   logic        reset;
   logic        reset8;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] rdata8;
   logic        irqout;
   logic        irqout8;
   logic        use8;

   typedef struct {
      logic        sel8;
      logic [31:0] data;
      logic        irq;
      string       name;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   logic [31:0] act_d;
   logic        act_i;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   timer_bank u_dut (
      .clk    (clk),
      .reset  (reset),
      .rd     (rd),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .irqout (irqout)
   );

   timer_bank #(.CNT_W(8)) u_dut8 (
      .clk    (clk),
      .reset  (reset8),
      .rd     (rd),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata8),
      .irqout (irqout8)
   );

   // Monitor: every cycle with rd high consumes one expected entry.
   always @(negedge clk) begin
      if (rd) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: addr=%h rdata=%h, required no read", addr, rdata);
         end else begin
            e     = sbq.pop_front();
            act_d = e.sel8 ? rdata8 : rdata;
            act_i = e.sel8 ? irqout8 : irqout;
            if (act_d !== e.data || act_i !== e.irq) begin
               errors++;
               $display("FAIL %s: rdata=%h irqout=%b, required rdata=%h irqout=%b",
                        e.name, act_d, act_i, e.data, e.irq);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100us");
      $fatal(1);
   end

   task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      @(posedge clk);
      #1;
      wr = 1'b0;
   endtask

   task automatic rd_cyc(input logic [31:0] a, input logic [31:0] ed, input logic ei,
                         input string nm);
      addr = a;
      rd   = 1'b1;
      sbq.push_back('{use8, ed, ei, nm});
      @(posedge clk);
      #1;
      rd = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset  = 1'b0;
      reset8 = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      addr   = '0;
      wdata  = '0;
      use8   = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(1);

      // Reset state of every mapped register plus one unmapped address
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            rd_cyc(B + 32'(16 * c + 4 * r), 32'h0, 1'b0, $sformatf("reset_ch%0d_reg%0d", c, r));
      rd_cyc(G,         32'h0, 1'b0, "reset_pend");
      rd_cyc(G + 32'd4, 32'h0, 1'b0, "reset_stat");
      rd_cyc(G + 32'd8, 32'h0, 1'b0, "reset_unmapped");

      // Channel 0: PRE=0, overflow every 16 cycles from F0
      wr_cyc(B + 32'h0, 32'hFFFF_FFF0);
      wr_cyc(B + 32'h4, 32'hFFFF_FFF0);
      rd_cyc(B + 32'h1, 32'h0, 1'b0, "unaligned_read");
      rd_cyc(B + 32'h0, 32'hFFFF_FFF0, 1'b0, "ch0_th");
      wr_cyc(B + 32'h8, 32'h3);
      idle(15);
      rd_cyc(G,         32'h0,         1'b0, "ch0_pend_before_ovf");
      rd_cyc(B + 32'h4, 32'hFFFF_FFF0, 1'b1, "ch0_tl_reloaded");
      rd_cyc(G,         32'h1,         1'b1, "ch0_pend_set");
      wr_cyc(G, 32'h1);
      rd_cyc(G,         32'h0,         1'b0, "ch0_pend_cleared");
      idle(11);
      rd_cyc(G,         32'h0,         1'b0, "ch0_pend_before_ovf2");
      rd_cyc(G,         32'h1,         1'b1, "ch0_second_ovf");
      wr_cyc(B + 32'h8, 32'h0);
      wr_cyc(G, 32'h1);

      // Channel 1: PRE=3 one-shot from FFFFFFFE
      wr_cyc(B + 32'h1C, 32'h3);
      wr_cyc(B + 32'h14, 32'hFFFF_FFFE);
      wr_cyc(B + 32'h18, 32'h7);
      idle(7);
      rd_cyc(G,          32'h0, 1'b0, "ch1_pend_before_ovf");
      rd_cyc(G,          32'h2, 1'b1, "ch1_oneshot_ovf");
      rd_cyc(B + 32'h14, 32'h0, 1'b1, "ch1_tl_reload");
      rd_cyc(G + 32'd4,  32'h0, 1'b1, "ch1_stat_cleared");
      rd_cyc(B + 32'h18, 32'h6, 1'b1, "ch1_ctrl_en_cleared");
      wr_cyc(G + 32'd4, 32'hF);
      rd_cyc(G + 32'd4,  32'h0, 1'b1, "stat_write_ignored");
      idle(20);
      rd_cyc(B + 32'h14, 32'h0, 1'b1, "ch1_tl_frozen");

      // Channel 1 auto-reload: W1C on the overflow edge loses to the set
      wr_cyc(G, 32'h2);
      rd_cyc(G, 32'h0, 1'b0, "ch1_pend_cleared");
      wr_cyc(B + 32'h14, 32'hFFFF_FFFE);
      wr_cyc(B + 32'h18, 32'h3);
      idle(7);
      wr_cyc(G, 32'h2);
      rd_cyc(G, 32'h2, 1'b1, "pend_set_beats_clear");
      wr_cyc(G, 32'h2);
      rd_cyc(G, 32'h0, 1'b0, "pend_w1c_alone");
      wr_cyc(B + 32'h18, 32'h0);

      // Channel 3 with IE=0, then IE=1, then reset mid-count
      wr_cyc(B + 32'h34, 32'hFFFF_FFFD);
      wr_cyc(B + 32'h3C, 32'h1);
      wr_cyc(B + 32'h38, 32'h1);
      idle(6);
      rd_cyc(G,          32'h8, 1'b0, "ch3_pend_ie0");
      wr_cyc(B + 32'h38, 32'h3);
      rd_cyc(G,          32'h8, 1'b1, "ch3_irq_after_ie");
      rd_cyc(B + 32'h34, 32'h1, 1'b1, "ch3_tl_counting");
      reset = 1'b0;
      rd_cyc(B + 32'h34, 32'h0, 1'b0, "async_reset_tl");
      rd_cyc(G,          32'h0, 1'b0, "async_reset_pend");

      // 8-bit build, channel 2: CPU TL write on the overflow tick wins
      use8   = 1'b1;
      reset8 = 1'b1;
      idle(1);
      wr_cyc(B + 32'h20, 32'hFFFF_FFF0);
      wr_cyc(B + 32'h24, 32'h0000_00FF);
      wr_cyc(B + 32'h28, 32'h1);
      wr_cyc(B + 32'h24, 32'h0000_0010);
      rd_cyc(B + 32'h24, 32'h0000_0010, 1'b0, "w8_tl_write_wins");
      rd_cyc(G,          32'h0,         1'b0, "w8_no_pend");
      rd_cyc(B + 32'h20, 32'h0000_00F0, 1'b0, "w8_th_truncated");
      wr_cyc(B + 32'h24, 32'h0000_00FF);
      rd_cyc(G,          32'h0,         1'b0, "w8_pend_before_wrap");
      rd_cyc(B + 32'h24, 32'h0000_00F0, 1'b0, "w8_tl_reload");
      rd_cyc(G,          32'h4,         1'b0, "w8_pend_ie0");

      idle(2);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: pending=%0d, required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Memory-mapped bank of N_CH independent timer/counter channels on the CPU peripheral bus (rd/wr/addr/wdata/rdata).
- Each channel supports a width-parametrised counter, an optional prescaler, and auto-reload or one-shot mode.
- Interrupts use per-channel pending bits with write-1-to-clear, combined into one interrupt line to the CPU.

Parameters:
- N_CH, 4, number of timer channels (1..8).
- CNT_W, 32, counter/reload width in bits (8..32).
- PRE_W, 16, prescaler width in bits (1..16).
- BASE_ADDR, 32'h40000100, byte address of channel 0 register TH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd  in  1  read strobe.
- wr  in  1  write strobe, sampled on rising clk.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- irqout  out  1  interrupt request to CPU, level.

Behaviour:
- Register map, channel i at BASE_ADDR + 16*i:
  - +0 TH: reload value, CNT_W bits.
  - +4 TL: counter, CNT_W bits.
  - +8 CTRL: bit0 EN, bit1 IE, bit2 ONESHOT; other bits read 0.
  - +C PRE: prescale divisor, PRE_W bits.
- Global registers at G = BASE_ADDR + 16*N_CH:
  - G+0 PEND: bit i = channel i pending; write 1 clears, write 0 has no effect.
  - G+4 STAT: bit i = channel i EN (read-only).
- Read path:
  - rdata = zero-extended register value when rd=1 and addr matches exactly.
  - Otherwise rdata = 0, including unaligned or unmapped addresses and rd=0.
  - Same-cycle combinational; reads have no side effects.
- Writes: wr=1 updates the addressed register at the clock edge; upper unused wdata bits are ignored. Writes to STAT and unmapped addresses are ignored.
- Reset (reset=0, async): all TH, TL, CTRL, PRE, PEND, prescale counters = 0; irqout = 0; rdata = 0 while rd=0.
- Per channel, each cycle with EN=1:
  - pcnt counts 0..PRE; tick asserted in the cycle pcnt==PRE, then pcnt returns to 0.
  - PRE=0 means tick every cycle.
  - EN=0: pcnt held at 0, no ticks.
- On a tick:
  - TL == all-ones (2^CNT_W-1): TL <= TH, PEND[i] <= 1, and if ONESHOT=1 then EN <= 0.
  - Otherwise TL <= TL+1, wrapping modulo 2^CNT_W.
- Overflow period with PRE=p, TH=h: (2^CNT_W - h)*(p+1) cycles from reload to the next pending set.
- PEND[i] is set regardless of IE; IE only gates the interrupt.
- irqout = OR over i of (PEND[i] & IE[i]); combinational from registers, so no extra latency. Asserts the cycle after the overflow edge.
- Simultaneous events, same edge:
  - CPU write to TL and tick on the same channel: the CPU write wins, no reload, no PEND set.
  - CPU write to CTRL and one-shot auto-clear: the CPU write wins.
  - PEND W1C and a new overflow on the same bit: the set wins, bit stays 1.
  - PRE write while running: pcnt is reset to 0 on the same edge.
  - CTRL write with EN 1->0: TL frozen, pcnt cleared.
- Reset mid-count: immediate async return to reset values; no pending survives.
- Channels are fully independent; no cross-channel carry.

Test Plan:
- Reset, then read every mapped address and an unmapped address (G+8) -> all rdata = 0; irqout = 0.
- Ch0: TH=FFFFFFF0, TL=FFFFFFF0, PRE=0, CTRL=3 -> PEND=1 and irqout=1 exactly 16 cycles after the CTRL write edge; TL reloads to FFFFFFF0; second overflow 16 cycles later.
- Ch1: PRE=3, TL=FFFFFFFE, TH=0, CTRL=7 (one-shot) -> overflow after 8 cycles; TL=0; STAT bit1 clears; TL stays 0 for the next 20 cycles.
- PEND write 0x2 in the same cycle ch1 overflows again (auto-reload mode) -> PEND bit1 remains 1. Then write 0x2 alone -> PEND bit1 = 0 and irqout = 0.
- CNT_W=8 build, ch2: TH=F0, TL=FF, tick in the same cycle as a CPU TL=10 write -> TL=10, PEND bit2 = 0. Read TL -> rdata=00000010.
- IE=0 channel overflows -> PEND bit set, irqout stays 0; set IE=1 -> irqout = 1 the next cycle. Assert reset mid-count -> TL=0, irqout=0 immediately, without waiting for a clock edge.
